// File: rtl/match_pkg.sv
// Shared defaults and types for the match collector slice.
package match_pkg;
  localparam int IDXW_DEF  = 16;
  localparam int DEPTH_DEF = 8;

  typedef logic [IDXW_DEF-1:0] widx_t;
endpackage

// File: rtl/match_fifo.sv
// Synchronous FIFO with pointer-derived full/empty and a registered head output.
module match_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic [W-1:0] dout_q, dout_d;
  logic         wr_en, rd_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
  assign dout_o  = dout_q;

  always_comb begin
    wr_en  = push_i && (!full_o || pop_i);
    rd_en  = pop_i && !empty_o;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + PTR_ONE;
    if (rd_en) rptr_d = rptr_q + PTR_ONE;
    // Head slot is being written this cycle when nothing else remains after the pop.
    if (wptr_q == rptr_d) dout_d = din_i;
    else                  dout_d = mem_q[rptr_d[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
    end
  end
endmodule

// File: rtl/match_collector.sv
// Collects window indices of matching end-of-window marks into a result FIFO,
// counting accepted matches and flagging dropped ones.
module match_collector
  import match_pkg::*;
#(
  parameter int IDXW  = IDXW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            markin,
  input  logic            sign,
  output logic [IDXW-1:0] dout,
  output logic            dvalid,
  input  logic            dready,
  output logic            full,
  output logic            overflow,
  output logic [IDXW-1:0] matchcnt
);
  logic [IDXW-1:0] widx_q, widx_d;
  logic [IDXW-1:0] matchcnt_q, matchcnt_d;
  logic            overflow_q, overflow_d;
  logic            mark_ok, push_req, pop, accept, drop, empty;

  assign mark_ok  = !ena && markin;
  assign push_req = mark_ok && sign;
  assign pop      = dvalid && dready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign accept   = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    widx_d     = widx_q;
    matchcnt_d = matchcnt_q;
    overflow_d = overflow_q;
    if (mark_ok) widx_d     = widx_q + IDXW'(1);
    if (accept)  matchcnt_d = matchcnt_q + IDXW'(1);
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      widx_q     <= '0;
      matchcnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      widx_q     <= widx_d;
      matchcnt_q <= matchcnt_d;
      overflow_q <= overflow_d;
    end
  end

  match_fifo #(
    .W     (IDXW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push_req),
    .din_i   (widx_q),
    .pop_i   (dready),
    .dout_o  (dout),
    .full_o  (full),
    .empty_o (empty)
  );

  assign dvalid   = !empty;
  assign overflow = overflow_q;
  assign matchcnt = matchcnt_q;
endmodule

// File: tb/tb_match_collector.sv
// Scoreboard bench: a queue-based reference model predicts each instance's FIFO
// contents and counters; a negedge monitor compares whatever the DUTs present.
module tb_match_collector;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        markin = 1'b0;
  logic        sign = 1'b0;
  logic        dready = 1'b0;

  logic [15:0] dout0, mc0;
  logic        dv0, f0, ov0;
  logic [3:0]  dout1, mc1;
  logic        dv1, f1, ov1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  match_collector #(.IDXW(16), .DEPTH(8)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .markin(markin), .sign(sign),
    .dout(dout0), .dvalid(dv0), .dready(dready), .full(f0),
    .overflow(ov0), .matchcnt(mc0)
  );

  match_collector #(.IDXW(4), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .markin(markin), .sign(sign),
    .dout(dout1), .dvalid(dv1), .dready(dready), .full(f1),
    .overflow(ov1), .matchcnt(mc1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: instance 0 is 16-bit/depth 8, instance 1 is 4-bit/depth 4.
  int exp_q [2][$];
  int widx_m [2];
  int mcnt_m [2];
  int ovf_m  [2];
  int depth_m [2] = '{8, 4};
  int mask_m  [2] = '{32'hFFFF, 32'hF};

  always @(posedge clk or negedge rst) begin
    bit pop_m, push_m, acc_m;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        exp_q[k].delete();
        widx_m[k] = 0;
        mcnt_m[k] = 0;
        ovf_m[k]  = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        pop_m  = dready && (exp_q[k].size() > 0);
        push_m = !ena && markin && sign;
        acc_m  = push_m && ((exp_q[k].size() < depth_m[k]) || pop_m);
        if (pop_m) void'(exp_q[k].pop_front());
        if (acc_m) begin
          exp_q[k].push_back(widx_m[k]);
          mcnt_m[k] = (mcnt_m[k] + 1) & mask_m[k];
        end else if (push_m) begin
          ovf_m[k] = 1;
        end
        if (!ena && markin) widx_m[k] = (widx_m[k] + 1) & mask_m[k];
      end
    end
  end

  task automatic mon(input int k, input string nm, input int dv, input int dout,
                     input int fl, input int ov, input int mc);
    chk({nm, "_dvalid"}, dv, (exp_q[k].size() != 0) ? 1 : 0);
    if (dv != 0 && exp_q[k].size() != 0) chk({nm, "_dout"}, dout, exp_q[k][0]);
    chk({nm, "_full"}, fl, (exp_q[k].size() == depth_m[k]) ? 1 : 0);
    chk({nm, "_overflow"}, ov, ovf_m[k]);
    chk({nm, "_matchcnt"}, mc, mcnt_m[k]);
  endtask

  always @(negedge clk) begin
    mon(0, "big", int'(dv0), int'(dout0), int'(f0), int'(ov0), int'(mc0));
    mon(1, "small", int'(dv1), int'(dout1), int'(f1), int'(ov1), int'(mc1));
  end

  task automatic step(input logic e, input logic m, input logic s, input logic r);
    ena = e; markin = m; sign = s; dready = r;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    ena = 1'b1; markin = 1'b0; sign = 1'b0; dready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_dvalid_big", int'(dv0), 0);
    chk("rst_dvalid_small", int'(dv1), 0);
    chk("rst_dout_big", int'(dout0), 0);
    #1;
    rst = 1'b1;
  endtask

  int wrapv [3] = '{14, 15, 0};
  int thr;

  initial begin
    @(negedge clk);
    #1;
    chk("reset_dvalid", int'(dv0), 0);
    chk("reset_matchcnt", int'(mc0), 0);
    rst = 1'b1;

    // Marks at windows 0..5, matches at 0, 3 and 5, consumer always ready.
    for (int w = 0; w < 6; w++) begin
      logic s;
      s = (w == 0 || w == 3 || w == 5);
      step(1'b0, 1'b1, s, 1'b1);
      if (s) begin
        chk("seq_dvalid", int'(dv0), 1);
        chk("seq_dout", int'(dout0), w);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("seq_empty", int'(dv0), 0);
    chk("seq_matchcnt", int'(mc0), 3);

    // Nine matches into a stalled consumer; the ninth is dropped.
    pulse_rst();
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      if (i == 7) chk("fill_full8", int'(f0), 1);
      if (i == 7) chk("fill_noovf8", int'(ov0), 0);
    end
    chk("fill_full", int'(f0), 1);
    chk("fill_overflow", int'(ov0), 1);
    chk("fill_matchcnt", int'(mc0), 8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_dout", int'(dout0), i);
      step(1'b1, 1'b0, 1'b0, 1'b1);
    end
    chk("drain_empty", int'(dv0), 0);
    chk("overflow_sticky", int'(ov0), 1);

    // Full FIFO with simultaneous push and pop.
    pulse_rst();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("pp_full_before", int'(f0), 1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("pp_overflow", int'(ov0), 0);
    chk("pp_full_after", int'(f0), 1);
    chk("pp_matchcnt", int'(mc0), 9);
    for (int i = 1; i <= 8; i++) begin
      chk("pp_drain", int'(dout0), i);
      step(1'b1, 1'b0, 1'b0, 1'b1);
    end

    // Stalled stage and unqualified sign are ignored.
    pulse_rst();
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("ena_hold", int'(dv0), 0);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("nomark_nopush", int'(dv0), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("first_mark_valid", int'(dv0), 1);
    chk("first_mark_idx0", int'(dout0), 0);

    // Index wrap on the 4-bit instance: 14, 15, 0.
    pulse_rst();
    repeat (14) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_dout", int'(dout1), wrapv[i]);
      step(1'b1, 1'b0, 1'b0, 1'b1);
    end

    // Reset mid-operation discards queued entries.
    pulse_rst();
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("midrst_queued", int'(dv0), 1);
    pulse_rst();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("midrst_nodeliver", int'(dv0), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("midrst_valid", int'(dv0), 1);
    chk("midrst_idx0", int'(dout0), 0);

    // Randomized traffic with varying consumer pressure.
    pulse_rst();
    for (int i = 0; i < 3000; i++) begin
      case ((i / 250) % 3)
        0:       thr = 90;
        1:       thr = 50;
        default: thr = 10;
      endcase
      if (i == 1500) pulse_rst();
      step(($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < thr));
    end
    repeat (12) step(1'b1, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
